line_buffer_reader: RTL and testbench
=====================================

Name: line_buffer_reader

Overview:
- Read-side sequencer for the graphics core's dual-port line buffer.
- On a line-start command, walks buffer addresses from a base for a given pixel count.
- Absorbs the buffer's one-cycle registered read latency and emits pixels on a valid/ready stream toward the video output stage.
- Sustains one pixel per clock under continuous ready and never drops or duplicates a pixel under backpressure.

Parameters:
- DATA_WIDTH, 16, pixel word width; matches the buffer data width.
- BUFFER_ADDR_WIDTH, 8, buffer address width; buffer depth is 2**BUFFER_ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- line_start  in  1  one-cycle command pulse; sampled only in IDLE.
- line_base  in  BUFFER_ADDR_WIDTH  first buffer address; sampled with line_start.
- line_count  in  BUFFER_ADDR_WIDTH+1  pixels in line, 0..2**BUFFER_ADDR_WIDTH; sampled with line_start.
- buf_read_addr  out  BUFFER_ADDR_WIDTH  address to buffer read port.
- buf_read_data  in  DATA_WIDTH  buffer read data, valid one clk after address.
- pix_data  out  DATA_WIDTH  output pixel.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accept.
- line_done  out  1  one-cycle pulse after the last pixel is accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: buf_read_addr=0, pix_data=0, pix_valid=0, line_done=0, busy=0, state=IDLE, skid empty, counters 0.
- Reset mid-line aborts immediately: no line_done, in-flight read discarded, skid flushed.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - line_start with line_count=0 -> line_done next cycle; stay IDLE.
  - line_start with line_count>0 -> latch base/count; go to FETCH.
- FETCH:
  - Issue a read (drive buf_read_addr, increment address) only when skid occupancy plus in-flight reads < 2.
  - Address wraps modulo 2**BUFFER_ADDR_WIDTH (base 0xFE, count 4 -> FE, FF, 00, 01).
  - After issuing count reads -> DRAIN.
- DRAIN:
  - When skid is empty and nothing in flight -> pulse line_done; go to IDLE.
- Read data is captured into a 2-entry skid FIFO the cycle after issue; the head drives pix_data/pix_valid.
- Handshake:
  - Transfer occurs when pix_valid && pix_ready.
  - Once asserted, pix_valid stays high and pix_data stays stable until transfer.
  - pix_valid never asserts without data.
- Latency: line_start at cycle N -> first address at N+1 -> first pix_valid at N+2. With pix_ready held high: one pixel/cycle; last pixel at N+1+count; line_done at N+2+count.
- Simultaneous events:
  - line_start while busy is ignored and not queued.
  - line_start in the same cycle as line_done is ignored.
  - pix_ready toggling arbitrarily loses nothing; the skid never overflows.
- Buffer contents must not be changed for the active range during a line; not checked.

Optional Feature:
- Macro: LINE_BUFFER_READER_HDOUBLE_EN (horizontal pixel doubling).
- When defined:
  - Adds input port hdouble_en (1 bit), sampled with line_start.
  - When it is high, each fetched pixel is presented twice (two transfers), so 2*line_count transfers occur.
  - Fetch rate is halved, and line_done follows the second copy of the last pixel.
- When undefined: no port and no doubling logic; behaviour as above.

Decomposition:
- Package line_buffer_pkg:
  - state enum (IDLE/FETCH/DRAIN).
  - SKID_DEPTH=2 constant.
  - Shared default widths DATA_WIDTH/BUFFER_ADDR_WIDTH, also used by the write side.
- One sub-module: line_reader_skid, a 2-entry valid/ready FIFO with push, pop, occupancy and flush.

Test Plan:
- Reset, then line_start base=0x10 count=4 with buffer[0x10..0x13]=A,B,C,D and ready high -> pix_valid at N+2..N+5 carrying A,B,C,D; line_done at N+6.
- Same line, pix_ready low for cycles N+3..N+6 -> output order A,B,C,D exact; pix_data stable while stalled; at most 2 reads outstanding.
- base=0xFE count=4 -> addresses FE, FF, 00, 01.
- count=0 -> line_done pulse next cycle, no pix_valid.
- count=256 -> 256 transfers, then line_done.
- Second line_start mid-line -> ignored.
- Reset asserted after 2 pixels -> all outputs 0 next cycle, no line_done.
- HDOUBLE_EN build with hdouble_en=1, count=2 (X,Y) -> transfers X,X,Y,Y, then line_done.

Source files
------------

// File: rtl/line_buffer_reader_pkg.sv
// Shared types and default widths for the line buffer read and write sides.
package line_buffer_pkg;

   localparam int DATA_WIDTH        = 16;
   localparam int BUFFER_ADDR_WIDTH = 8;
   localparam int SKID_DEPTH        = 2;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } readState_e;

endpackage

// File: rtl/line_buffer_reader_if.sv
// Command, buffer read port and pixel stream bundle for line_buffer_reader.
// hdouble_en exists only when LINE_BUFFER_READER_HDOUBLE_EN is defined.
interface line_buffer_reader_if #(
   parameter int DATA_WIDTH        = line_buffer_pkg::DATA_WIDTH,
   parameter int BUFFER_ADDR_WIDTH = line_buffer_pkg::BUFFER_ADDR_WIDTH
);

   logic                         line_start;
   logic [BUFFER_ADDR_WIDTH-1:0] line_base;
   logic [BUFFER_ADDR_WIDTH:0]   line_count;
   logic [BUFFER_ADDR_WIDTH-1:0] buf_read_addr;
   logic [DATA_WIDTH-1:0]        buf_read_data;
   logic [DATA_WIDTH-1:0]        pix_data;
   logic                         pix_valid;
   logic                         pix_ready;
   logic                         line_done;
   logic                         busy;
`ifdef LINE_BUFFER_READER_HDOUBLE_EN
   logic                         hdouble_en;

   modport master (
      output line_start, line_base, line_count, buf_read_data, pix_ready, hdouble_en,
      input  buf_read_addr, pix_data, pix_valid, line_done, busy
   );

   modport slave (
      input  line_start, line_base, line_count, buf_read_data, pix_ready, hdouble_en,
      output buf_read_addr, pix_data, pix_valid, line_done, busy
   );
`else
   modport master (
      output line_start, line_base, line_count, buf_read_data, pix_ready,
      input  buf_read_addr, pix_data, pix_valid, line_done, busy
   );

   modport slave (
      input  line_start, line_base, line_count, buf_read_data, pix_ready,
      output buf_read_addr, pix_data, pix_valid, line_done, busy
   );
`endif

endinterface

// File: rtl/line_reader_skid.sv
// Two-entry fall-through FIFO: read data arriving while empty is presented the same
// cycle, so the buffer's registered read latency costs no extra pixel cycle.
module line_reader_skid
   import line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = line_buffer_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] pushData_i,
   input  logic                  pop_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [1:0]            level_o
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic                  wrPtr_q;
   logic                  rdPtr_q;
   logic [1:0]            level_q;
   logic [1:0]            level_d;
   logic                  stored;
   logic                  write;
   logic                  popStored;

   always_comb begin
      stored    = (level_q != 2'd0);
      popStored = pop_i && stored;
      write     = push_i && !(pop_i && !stored);
      level_d   = level_q + 2'(write) - 2'(popStored);
      valid_o   = stored || push_i;
      data_o    = '0;
      if (stored) begin
         data_o = mem_q[rdPtr_q];
      end else if (push_i) begin
         data_o = pushData_i;
      end
      level_o   = level_q;
   end

   // One-bit pointers wrap naturally at depth two.
   always_ff @(posedge clk) begin
      if (flush_i) begin
         level_q <= 2'd0;
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
      end else begin
         level_q <= level_d;
         if (write) begin
            mem_q[wrPtr_q] <= pushData_i;
            wrPtr_q        <= ~wrPtr_q;
         end
         if (popStored) begin
            rdPtr_q <= ~rdPtr_q;
         end
      end
   end

endmodule

// File: rtl/line_buffer_reader.sv
// Read-side sequencer: walks line buffer addresses and streams pixels on valid/ready.
// Optional horizontal pixel doubling is enabled by LINE_BUFFER_READER_HDOUBLE_EN.
module line_buffer_reader
   import line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH        = line_buffer_pkg::DATA_WIDTH,
   parameter int BUFFER_ADDR_WIDTH = line_buffer_pkg::BUFFER_ADDR_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   line_buffer_reader_if.slave  bus
);

   localparam int AW = BUFFER_ADDR_WIDTH;
   localparam int CW = BUFFER_ADDR_WIDTH + 1;

   readState_e            state_q, state_d;
   logic [AW-1:0]         readAddr_q, readAddr_d;
   logic [CW-1:0]         remain_q, remain_d;
   logic                  inflight_q;
   logic                  done_q, done_d;
   logic                  issue;
   logic                  accept;
   logic                  lineEmpty;
   logic                  transfer;
   logic                  popNow;
   logic [1:0]            level;
   logic [1:0]            levelSum;
   logic                  skidValid;
   logic [DATA_WIDTH-1:0] skidData;

   // Reads are throttled so stored entries plus the outstanding read never exceed the skid.
   always_comb begin
      levelSum  = level + {1'b0, inflight_q};
      issue     = (state_q == FETCH) && (levelSum < 2'(SKID_DEPTH));
      lineEmpty = (level == 2'd0) && !inflight_q;
      accept    = (state_q == IDLE) && bus.line_start && !done_q;
      transfer  = skidValid && bus.pix_ready;
   end

`ifdef LINE_BUFFER_READER_HDOUBLE_EN
   logic dbl_q, dbl_d;
   logic second_q, second_d;

   // A doubled pixel leaves the skid only on its second transfer.
   always_comb begin
      dbl_d    = accept ? bus.hdouble_en : dbl_q;
      second_d = second_q;
      if (transfer && dbl_q) begin
         second_d = !second_q;
      end
      popNow   = transfer && (!dbl_q || second_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dbl_q    <= 1'b0;
         second_q <= 1'b0;
      end else begin
         dbl_q    <= dbl_d;
         second_q <= second_d;
      end
   end
`else
   always_comb begin
      popNow = transfer;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         readAddr_q <= '0;
         remain_q   <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         readAddr_q <= readAddr_d;
         remain_q   <= remain_d;
         inflight_q <= issue;
         done_q     <= done_d;
      end
   end

   // An empty line finishes from IDLE through the registered done pulse.
   always_comb begin
      state_d    = state_q;
      readAddr_d = readAddr_q;
      remain_d   = remain_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.line_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  readAddr_d = bus.line_base;
                  remain_d   = bus.line_count;
                  state_d    = FETCH;
               end
            end
         end
         FETCH: begin
            if (issue) begin
               readAddr_d = readAddr_q + AW'(1);
               remain_d   = remain_q - CW'(1);
               if (remain_q == CW'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (lineEmpty) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.buf_read_addr = readAddr_q;
      bus.pix_valid     = skidValid;
      bus.pix_data      = skidData;
      bus.line_done     = done_q || ((state_q == DRAIN) && lineEmpty);
      bus.busy          = (state_q != IDLE);
   end

   line_reader_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) skid (
      .clk        (clk),
      .flush_i    (reset),
      .push_i     (inflight_q),
      .pushData_i (bus.buf_read_data),
      .pop_i      (popNow),
      .valid_o    (skidValid),
      .data_o     (skidData),
      .level_o    (level)
   );

endmodule

// File: tb/tb_line_buffer_reader.sv
// Directed self-checking bench for line_buffer_reader with a registered-read buffer model.
module tb_line_buffer_reader;

   localparam int DW = 16;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   line_buffer_reader_if #(.DATA_WIDTH(DW), .BUFFER_ADDR_WIDTH(AW)) lbIf ();

   line_buffer_reader #(.DATA_WIDTH(DW), .BUFFER_ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (lbIf.slave)
   );

   // Every word encodes its own address, so A500|addr identifies the pixel fetched.
   logic [DW-1:0] mem [256];

   always @(posedge clk) lbIf.buf_read_data <= mem[lbIf.buf_read_addr];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one line; stall window and a mid-line line_start are optional (-1 disables).
   task automatic applyStimulus(input logic [7:0] base, input logic [8:0] count, input bit dbl,
                                input int stallFrom, input int stallTo, input int midStartAt,
                                input int expDoneK);
      logic [15:0] got [$];
      int          doneK;
      bit          prevValid;
      bit          prevXfer;
      logic [15:0] prevData;
      int          nExp;
      logic [7:0]  a;
      doneK     = -1;
      prevValid = 1'b0;
      prevXfer  = 1'b0;
      prevData  = '0;
      lbIf.line_base  = base;
      lbIf.line_count = count;
`ifdef LINE_BUFFER_READER_HDOUBLE_EN
      lbIf.hdouble_en = dbl;
`endif
      lbIf.line_start = 1'b1;
      lbIf.pix_ready  = 1'b1;
      tick;
      lbIf.line_start = 1'b0;
      for (int k = 1; k <= 600 && doneK < 0; k++) begin
         bit rdy;
         rdy = !(k >= stallFrom && k <= stallTo);
         lbIf.pix_ready = rdy;
         if (k == midStartAt) begin
            lbIf.line_start = 1'b1;
            lbIf.line_base  = 8'h40;
            lbIf.line_count = 9'd5;
         end else begin
            lbIf.line_start = 1'b0;
         end
         if (stallFrom < 0 && !dbl && k <= int'(count) && count <= 9'd8) begin
            a = base + 8'(k - 1);
            checkOutput("read_addr", 32'(lbIf.buf_read_addr), 32'(a));
         end
         if (prevValid && !prevXfer) begin
            checkOutput("hold_valid", 32'(lbIf.pix_valid), 32'd1);
            checkOutput("hold_data", 32'(lbIf.pix_data), 32'(prevData));
         end
         if (lbIf.pix_valid && rdy) got.push_back(lbIf.pix_data);
         if (lbIf.line_done) doneK = k;
         prevValid = lbIf.pix_valid;
         prevXfer  = lbIf.pix_valid && rdy;
         prevData  = lbIf.pix_data;
         tick;
      end
      lbIf.line_start = 1'b0;
      checkOutput("done_cycle", 32'(doneK), 32'(expDoneK));
      nExp = dbl ? 2 * int'(count) : int'(count);
      checkOutput("xfer_count", 32'(got.size()), 32'(nExp));
      for (int j = 0; j < got.size() && j < nExp; j++) begin
         a = base + 8'(dbl ? j / 2 : j);
         checkOutput("pix_order", 32'(got[j]), 32'(16'hA500 | {8'h00, a}));
      end
      checkOutput("done_pulse", 32'(lbIf.line_done), 32'd0);
      checkOutput("idle_busy", 32'(lbIf.busy), 32'd0);
      checkOutput("idle_valid", 32'(lbIf.pix_valid), 32'd0);
   endtask

   initial begin
      bit sawDone;
      for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
      lbIf.line_start = 1'b0;
      lbIf.line_base  = '0;
      lbIf.line_count = '0;
      lbIf.pix_ready  = 1'b0;
`ifdef LINE_BUFFER_READER_HDOUBLE_EN
      lbIf.hdouble_en = 1'b0;
`endif
      reset = 1'b1;
      tick;
      tick;
      checkOutput("rst_valid", 32'(lbIf.pix_valid), 32'd0);
      checkOutput("rst_data", 32'(lbIf.pix_data), 32'd0);
      checkOutput("rst_addr", 32'(lbIf.buf_read_addr), 32'd0);
      checkOutput("rst_done", 32'(lbIf.line_done), 32'd0);
      checkOutput("rst_busy", 32'(lbIf.busy), 32'd0);
      reset = 1'b0;
      tick;

      $display("[TB] basic line, stall, wrap, ignored start, full depth");
      applyStimulus(8'h10, 9'd4, 1'b0, -1, -1, -1, 6);
      applyStimulus(8'h10, 9'd4, 1'b0, 3, 6, -1, 10);
      applyStimulus(8'hFE, 9'd4, 1'b0, -1, -1, -1, 6);
      applyStimulus(8'h20, 9'd3, 1'b0, -1, -1, 2, 5);
      applyStimulus(8'h00, 9'd256, 1'b0, -1, -1, -1, 258);

      $display("[TB] empty line and start coinciding with done");
      lbIf.line_base  = 8'h00;
      lbIf.line_count = 9'd0;
      lbIf.line_start = 1'b1;
      tick;
      lbIf.line_count = 9'd4;
      checkOutput("zero_done", 32'(lbIf.line_done), 32'd1);
      checkOutput("zero_valid", 32'(lbIf.pix_valid), 32'd0);
      checkOutput("zero_busy", 32'(lbIf.busy), 32'd0);
      tick;
      lbIf.line_start = 1'b0;
      checkOutput("zero_done_end", 32'(lbIf.line_done), 32'd0);
      checkOutput("start_on_done_busy", 32'(lbIf.busy), 32'd0);
      checkOutput("start_on_done_valid", 32'(lbIf.pix_valid), 32'd0);

      $display("[TB] reset in the middle of a line");
      lbIf.line_base  = 8'h30;
      lbIf.line_count = 9'd6;
      lbIf.pix_ready  = 1'b1;
      lbIf.line_start = 1'b1;
      tick;
      lbIf.line_start = 1'b0;
      tick;
      checkOutput("mid_pix0", 32'(lbIf.pix_data), 32'h0000A530);
      tick;
      checkOutput("mid_pix1", 32'(lbIf.pix_data), 32'h0000A531);
      reset = 1'b1;
      tick;
      checkOutput("mid_rst_valid", 32'(lbIf.pix_valid), 32'd0);
      checkOutput("mid_rst_data", 32'(lbIf.pix_data), 32'd0);
      checkOutput("mid_rst_addr", 32'(lbIf.buf_read_addr), 32'd0);
      checkOutput("mid_rst_done", 32'(lbIf.line_done), 32'd0);
      checkOutput("mid_rst_busy", 32'(lbIf.busy), 32'd0);
      reset   = 1'b0;
      sawDone = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (lbIf.line_done || lbIf.pix_valid) sawDone = 1'b1;
         tick;
      end
      checkOutput("post_rst_quiet", 32'(sawDone), 32'd0);

`ifdef LINE_BUFFER_READER_HDOUBLE_EN
      $display("[TB] horizontal doubling");
      applyStimulus(8'h50, 9'd2, 1'b1, -1, -1, -1, 6);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
